// File: rtl/ifetch_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ifetch_refill_ctrl                                              |
// | Purpose  : Two-slot instruction line tracker and refill sequencer. It       |
// |            reports whether both words of a fetch pair are resident. It      |
// |            requests missing 64B lines from local store and streams the      |
// |            returned 128-bit beats into the line buffer.                     |
// | Options  : IFETCH_PREFETCH_EN - when defined, an idle controller that sees  |
// |            line(pc) resident and line(pc)+1 absent prefetches line+1 into   |
// |            the other slot.                                                  |
// | Ports    : clk, rst_n          clock, async active-low reset                |
// |            i_fetch_req/pc      fetch pair request, word address             |
// |            i_redirect          flush pulse (withdraws an ungranted request) |
// |            o_fetch_hit/buf_idx pair resident / buffer index of fetch_pc     |
// |            o_ls_req/line, i_ls_gnt            LS request handshake          |
// |            i_ls_rvalid/rdata                  LS return beats               |
// |            o_buf_we/waddr/wdata               line buffer write port        |
// |            o_tag_valid         per-slot valid bits {slot1, slot0}           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ifetch_refill_ctrl #(
   parameter int LINE_BEATS = 4,   // 128-bit beats per line, power of two >= 2
   parameter int LINE_AW    = 12   // line address width
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_fetch_req,
   input  logic [15:0]                   i_fetch_pc,
   input  logic                          i_redirect,
   output logic                          o_fetch_hit,
   output logic [4:0]                    o_fetch_buf_idx,
   output logic                          o_ls_req,
   output logic [LINE_AW-1:0]            o_ls_line,
   input  logic                          i_ls_gnt,
   input  logic                          i_ls_rvalid,
   input  logic [127:0]                  i_ls_rdata,
   output logic                          o_buf_we,
   output logic [$clog2(LINE_BEATS):0]   o_buf_waddr,
   output logic [127:0]                  o_buf_wdata,
   output logic [1:0]                    o_tag_valid
);

   localparam int BW = $clog2(LINE_BEATS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BW-1:0]       r_beat;
   logic                r_lru;        // slot to evict when neither needed line is resident
   logic                r_victim;
   logic [LINE_AW-1:0]  r_ls_line;
   logic [1:0]          r_valid;
   logic [LINE_AW-1:0]  r_tag [2];

   // Lookup of the line holding fetch_pc and the line after it (wraps at top)
   logic [LINE_AW-1:0]  w_line0;
   logic [LINE_AW-1:0]  w_line1;
   logic                w_m0_s0, w_m0_s1, w_m1_s0, w_m1_s1;
   logic                w_res0, w_res1, w_slot0, w_slot1;
   logic                w_straddle, w_need0, w_need1, w_demand, w_prefetch;
   logic                w_start, w_victim, w_last;
   logic [LINE_AW-1:0]  w_req_line;

   assign w_line0 = LINE_AW'(i_fetch_pc[15:4]);
   assign w_line1 = w_line0 + LINE_AW'(1);

   assign w_m0_s0 = r_valid[0] && (r_tag[0] == w_line0);
   assign w_m0_s1 = r_valid[1] && (r_tag[1] == w_line0);
   assign w_m1_s0 = r_valid[0] && (r_tag[0] == w_line1);
   assign w_m1_s1 = r_valid[1] && (r_tag[1] == w_line1);
   assign w_res0  = w_m0_s0 || w_m0_s1;
   assign w_res1  = w_m1_s0 || w_m1_s1;
   assign w_slot0 = w_m0_s1;
   assign w_slot1 = w_m1_s1;

   // Word 15 pairs with word 0 of the next line
   assign w_straddle = &i_fetch_pc[3:0];
   assign w_need0    = !w_res0;
   assign w_need1    = w_straddle && !w_res1;
   assign w_demand   = i_fetch_req && (w_need0 || w_need1);

   assign o_fetch_hit     = w_res0 && (!w_straddle || w_res1);
   assign o_fetch_buf_idx = {w_slot0, i_fetch_pc[3:0]};

`ifdef IFETCH_PREFETCH_EN
   assign w_prefetch = i_fetch_req && !w_demand && w_res0 && !w_res1;
`else
   assign w_prefetch = 1'b0;
`endif

   assign w_start = (r_state == S_IDLE) && (w_demand || w_prefetch);

   // The lower-addressed missing line goes first. The victim must never be
   // the slot holding the other half of the pair. Prefetch shares the
   // need0=0 path, so it targets the slot opposite line(pc).
   assign w_req_line = w_need0 ? w_line0 : w_line1;
   assign w_victim   = w_need0 ? ((w_straddle && w_res1) ? ~w_slot1 : r_lru)
                               : ~w_slot0;

   assign w_last = (r_beat == BW'(LINE_BEATS - 1));

   assign o_ls_line   = r_ls_line;
   assign o_tag_valid = r_valid;

   always_comb begin
      w_state_nxt = r_state;
      o_ls_req    = 1'b0;
      o_buf_we    = 1'b0;
      o_buf_waddr = '0;
      o_buf_wdata = '0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            o_ls_req = 1'b1;
            // A grant in the same cycle as redirect still wins
            if (i_ls_gnt)        w_state_nxt = S_FILL;
            else if (i_redirect) w_state_nxt = S_IDLE;
         end
         S_FILL: begin
            // Beats pass straight through to the buffer; redirect cannot abort
            if (i_ls_rvalid) begin
               o_buf_we    = 1'b1;
               o_buf_waddr = {r_victim, r_beat};
               o_buf_wdata = i_ls_rdata;
               if (w_last) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat    <= '0;
         r_lru     <= 1'b0;
         r_victim  <= 1'b0;
         r_ls_line <= '0;
         r_valid   <= '0;
         r_tag[0]  <= '0;
         r_tag[1]  <= '0;
      end else begin
         if (i_fetch_req && o_fetch_hit) r_lru <= ~w_slot0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_ls_line          <= w_req_line;
                  r_victim           <= w_victim;
                  r_valid[w_victim]  <= 1'b0;
               end
            end
            S_REQ: begin
               if (i_ls_gnt) r_beat <= '0;
            end
            S_FILL: begin
               if (i_ls_rvalid) begin
                  r_beat <= r_beat + BW'(1);
                  if (w_last) begin
                     r_tag[r_victim]   <= r_ls_line;
                     r_valid[r_victim] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ifetch_refill_ctrl                                           |
// | Purpose  : Directed vector bench for ifetch_refill_ctrl                     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ifetch_refill_ctrl;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_fetch_req = 1'b0;
   logic [15:0]   i_fetch_pc = '0;
   logic          i_redirect = 1'b0;
   logic          o_fetch_hit;
   logic [4:0]    o_fetch_buf_idx;
   logic          o_ls_req;
   logic [11:0]   o_ls_line;
   logic          i_ls_gnt = 1'b0;
   logic          i_ls_rvalid = 1'b0;
   logic [127:0]  i_ls_rdata = '0;
   logic          o_buf_we;
   logic [2:0]    o_buf_waddr;
   logic [127:0]  o_buf_wdata;
   logic [1:0]    o_tag_valid;

   int n_chk  = 0;
   int n_pass = 0;

   ifetch_refill_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_fetch_req     (i_fetch_req),
      .i_fetch_pc      (i_fetch_pc),
      .i_redirect      (i_redirect),
      .o_fetch_hit     (o_fetch_hit),
      .o_fetch_buf_idx (o_fetch_buf_idx),
      .o_ls_req        (o_ls_req),
      .o_ls_line       (o_ls_line),
      .i_ls_gnt        (i_ls_gnt),
      .i_ls_rvalid     (i_ls_rvalid),
      .i_ls_rdata      (i_ls_rdata),
      .o_buf_we        (o_buf_we),
      .o_buf_waddr     (o_buf_waddr),
      .o_buf_wdata     (o_buf_wdata),
      .o_tag_valid     (o_tag_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         req;
      logic [15:0]  pc;
      logic         redir;
      logic         gnt;
      logic         rv;
      logic [127:0] rd;
      logic         hit;
      logic [4:0]   idx;
      logic         lsreq;
      logic [11:0]  line;
      logic         we;
      logic [2:0]   wa;
      logic [1:0]   tv;
   } vec_t;

   function automatic vec_t mk(
      input logic req, input logic [15:0] pc, input logic redir, input logic gnt,
      input logic rv, input logic [127:0] rd,
      input logic hit, input logic [4:0] idx, input logic lsreq, input logic [11:0] line,
      input logic we, input logic [2:0] wa, input logic [1:0] tv);
      vec_t v;
      v.req = req; v.pc = pc; v.redir = redir; v.gnt = gnt; v.rv = rv; v.rd = rd;
      v.hit = hit; v.idx = idx; v.lsreq = lsreq; v.line = line;
      v.we = we; v.wa = wa; v.tv = tv;
      return v;
   endfunction

   function automatic logic [127:0] dat(input int n);
      logic [31:0] w;
      w = 32'hA5A5_0000 + 32'(n);
      return {w, ~w, w, ~w};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Apply inputs just after the rising edge, compare on the falling edge
   task automatic run_vec(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      i_fetch_req = v.req;
      i_fetch_pc  = v.pc;
      i_redirect  = v.redir;
      i_ls_gnt    = v.gnt;
      i_ls_rvalid = v.rv;
      i_ls_rdata  = v.rd;
      @(negedge clk);
      chk({tag, " fetch_hit"}, 128'(o_fetch_hit),     128'(v.hit));
      chk({tag, " buf_idx"},   128'(o_fetch_buf_idx), 128'(v.idx));
      chk({tag, " ls_req"},    128'(o_ls_req),        128'(v.lsreq));
      chk({tag, " ls_line"},   128'(o_ls_line),       128'(v.line));
      chk({tag, " buf_we"},    128'(o_buf_we),        128'(v.we));
      chk({tag, " buf_waddr"}, 128'(o_buf_waddr),     128'(v.wa));
      chk({tag, " buf_wdata"}, o_buf_wdata,           v.we ? v.rd : 128'h0);
      chk({tag, " tag_valid"}, 128'(o_tag_valid),     128'(v.tv));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   vec_t tbl [18];

   initial begin
      // Demand fill of line 0x004 into slot 0, then straddle fill of 0x005 into slot 1
      tbl[0]  = mk(0,16'h0000,0,0,0,'0,       0,5'h00,0,12'h000,0,3'd0,2'b00);
      tbl[1]  = mk(1,16'h0040,0,0,0,'0,       0,5'h00,0,12'h000,0,3'd0,2'b00);
      tbl[2]  = mk(1,16'h0040,0,0,0,'0,       0,5'h00,1,12'h004,0,3'd0,2'b00);
      tbl[3]  = mk(1,16'h0040,0,1,0,'0,       0,5'h00,1,12'h004,0,3'd0,2'b00);
      tbl[4]  = mk(1,16'h0040,0,0,1,dat(0),   0,5'h00,0,12'h004,1,3'd0,2'b00);
      tbl[5]  = mk(1,16'h0040,0,0,0,'0,       0,5'h00,0,12'h004,0,3'd0,2'b00);
      tbl[6]  = mk(1,16'h0040,0,0,1,dat(1),   0,5'h00,0,12'h004,1,3'd1,2'b00);
      tbl[7]  = mk(1,16'h0040,0,0,1,dat(2),   0,5'h00,0,12'h004,1,3'd2,2'b00);
      tbl[8]  = mk(1,16'h0040,0,0,1,dat(3),   0,5'h00,0,12'h004,1,3'd3,2'b00);
      tbl[9]  = mk(0,16'h0040,0,0,0,'0,       1,5'h00,0,12'h004,0,3'd0,2'b01);
      tbl[10] = mk(1,16'h004F,0,0,0,'0,       0,5'h0F,0,12'h004,0,3'd0,2'b01);
      tbl[11] = mk(1,16'h004F,0,1,0,'0,       0,5'h0F,1,12'h005,0,3'd0,2'b01);
      tbl[12] = mk(1,16'h004F,0,0,1,dat(4),   0,5'h0F,0,12'h005,1,3'd4,2'b01);
      tbl[13] = mk(1,16'h004F,0,0,1,dat(5),   0,5'h0F,0,12'h005,1,3'd5,2'b01);
      tbl[14] = mk(1,16'h004F,0,0,1,dat(6),   0,5'h0F,0,12'h005,1,3'd6,2'b01);
      tbl[15] = mk(1,16'h004F,0,0,1,dat(7),   0,5'h0F,0,12'h005,1,3'd7,2'b01);
      tbl[16] = mk(1,16'h004F,0,0,0,'0,       1,5'h0F,0,12'h005,0,3'd0,2'b11);
      tbl[17] = mk(0,16'h0050,0,0,1,dat(8),   1,5'h10,0,12'h005,0,3'd0,2'b11);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("v%0d", i));

      // A: lru victim (slot 1), ungranted request held stable, redirect withdraws it
      run_vec(mk(1,16'h0080,0,0,0,'0, 0,5'h00,0,12'h005,0,3'd0,2'b11), "a0");
      run_vec(mk(0,16'h0080,0,0,0,'0, 0,5'h00,1,12'h008,0,3'd0,2'b01), "a1");
      run_vec(mk(0,16'h0080,0,0,0,'0, 0,5'h00,1,12'h008,0,3'd0,2'b01), "a2");
      run_vec(mk(0,16'h0080,1,0,0,'0, 0,5'h00,1,12'h008,0,3'd0,2'b01), "a3");
      run_vec(mk(0,16'h0080,0,0,0,'0, 0,5'h00,0,12'h008,0,3'd0,2'b01), "a4");
      run_vec(mk(0,16'h0080,0,0,0,'0, 0,5'h00,0,12'h008,0,3'd0,2'b01), "a5");

      // B: five-cycle grant wait, grant beats redirect, redirect during beat 2
      run_vec(mk(1,16'h0080,0,0,0,'0, 0,5'h00,0,12'h008,0,3'd0,2'b01), "b0");
      for (int k = 1; k <= 5; k++)
         run_vec(mk(0,16'h0080,0,0,0,'0, 0,5'h00,1,12'h008,0,3'd0,2'b01), $sformatf("b%0d", k));
      run_vec(mk(0,16'h0080,1,1,0,'0,       0,5'h00,1,12'h008,0,3'd0,2'b01), "b6");
      run_vec(mk(0,16'h0080,0,0,1,dat(10),  0,5'h00,0,12'h008,1,3'd4,2'b01), "b7");
      run_vec(mk(0,16'h0080,0,0,1,dat(11),  0,5'h00,0,12'h008,1,3'd5,2'b01), "b8");
      run_vec(mk(0,16'h0080,1,0,1,dat(12),  0,5'h00,0,12'h008,1,3'd6,2'b01), "b9");
      run_vec(mk(0,16'h0080,0,0,1,dat(13),  0,5'h00,0,12'h008,1,3'd7,2'b01), "b10");
      run_vec(mk(0,16'h0080,0,0,0,'0,       1,5'h10,0,12'h008,0,3'd0,2'b11), "b11");

      // C: reset in the middle of a fill; late beats afterwards are ignored
      run_vec(mk(1,16'h00C0,0,0,0,'0,       0,5'h00,0,12'h008,0,3'd0,2'b11), "c0");
      run_vec(mk(0,16'h00C0,0,1,0,'0,       0,5'h00,1,12'h00C,0,3'd0,2'b01), "c1");
      run_vec(mk(0,16'h00C0,0,0,1,dat(20),  0,5'h00,0,12'h00C,1,3'd4,2'b01), "c2");
      run_vec(mk(0,16'h00C0,0,0,1,dat(21),  0,5'h00,0,12'h00C,1,3'd5,2'b01), "c3");
      #1;
      rst_n       = 1'b0;
      i_fetch_pc  = 16'h0040;
      i_ls_rdata  = dat(22);
      #1;
      chk("rst tag_valid", 128'(o_tag_valid), 128'(2'b00));
      chk("rst ls_req",    128'(o_ls_req),    128'(1'b0));
      chk("rst ls_line",   128'(o_ls_line),   128'(12'h000));
      chk("rst buf_we",    128'(o_buf_we),    128'(1'b0));
      chk("rst buf_waddr", 128'(o_buf_waddr), 128'(3'd0));
      chk("rst buf_wdata", o_buf_wdata,       128'h0);
      chk("rst fetch_hit", 128'(o_fetch_hit), 128'(1'b0));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(0,16'h0040,0,0,1,dat(22), 0,5'h00,0,12'h000,0,3'd0,2'b00), "c4");
      run_vec(mk(0,16'h0040,0,0,1,dat(23), 0,5'h00,0,12'h000,0,3'd0,2'b00), "c5");

      // D: line 0xFFF into slot 0, then pc 0xFFFF needs line 0x000 (wrap)
      run_vec(mk(1,16'hFFF0,0,0,0,'0, 0,5'h00,0,12'h000,0,3'd0,2'b00), "d0");
      run_vec(mk(0,16'hFFF0,0,1,0,'0, 0,5'h00,1,12'hFFF,0,3'd0,2'b00), "d1");
      for (int k = 0; k < 4; k++)
         run_vec(mk(0,16'hFFF0,0,0,1,dat(30+k), 0,5'h00,0,12'hFFF,1,3'(k),2'b00),
                 $sformatf("d%0d", 2+k));
      run_vec(mk(1,16'hFFFF,0,0,0,'0, 0,5'h0F,0,12'hFFF,0,3'd0,2'b01), "d6");
      run_vec(mk(0,16'hFFFF,0,1,0,'0, 0,5'h0F,1,12'h000,0,3'd0,2'b01), "d7");
      for (int k = 0; k < 4; k++)
         run_vec(mk(0,16'hFFFF,0,0,1,dat(40+k), 0,5'h0F,0,12'h000,1,3'(4+k),2'b01),
                 $sformatf("d%0d", 8+k));
      run_vec(mk(1,16'hFFFF,0,0,0,'0, 1,5'h0F,0,12'h000,0,3'd0,2'b11), "d12");

      // E: line 0x000 resident in slot 1, fetch inside it; prefetch only when enabled
      run_vec(mk(1,16'h0001,0,0,0,'0, 1,5'h11,0,12'h000,0,3'd0,2'b11), "e0");
`ifdef IFETCH_PREFETCH_EN
      run_vec(mk(0,16'h0001,0,1,0,'0, 1,5'h11,1,12'h001,0,3'd0,2'b10), "e1");
      for (int k = 0; k < 4; k++)
         run_vec(mk(0,16'h0001,0,0,1,dat(50+k), 1,5'h11,0,12'h001,1,3'(k),2'b10),
                 $sformatf("e%0d", 2+k));
      run_vec(mk(0,16'h0010,0,0,0,'0, 1,5'h00,0,12'h001,0,3'd0,2'b11), "e6");
`else
      run_vec(mk(0,16'h0001,0,0,0,'0, 1,5'h11,0,12'h000,0,3'd0,2'b11), "e1");
      run_vec(mk(0,16'h0010,0,0,0,'0, 0,5'h00,0,12'h000,0,3'd0,2'b11), "e2");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
